eth_tx_scheduler: RTL and testbench

Round-robin transmit scheduler that shares the single frame-encapsulation TX path between `N_REQ` payload-buffer requesters. It grants one requester at a time and drives the encapsulator's `eth_tx_en` / `buffer_ready` controls. It routes the granted requester's payload bytes and read enable, detects frame completion via `pct_txed`, enforces an inter-frame gap, and recovers from a stalled frame with a watchdog that resets the encapsulator. It sits between the payload buffers and the encapsulation block, in the `eth_tx_clk` domain.

---
 rtl/eth_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_scheduler.sv
// Round-robin TX scheduler: shares one encapsulator among N_REQ payload buffers
// with an inter-frame gap and a watchdog that resets a stalled encapsulator.
//
// Ports:
//   eth_tx_clk, rst (sync, active-low)
//   req / req_data        : requester frame-ready levels and payload bytes
//   req_r_en              : enc_buf_r_en routed to the granted requester
//   gnt / done            : one-hot grant, frame-complete pulse
//   abort / busy          : watchdog pulse, not-idle flag
//   eth_tx_en, enc_buffer_ready, enc_data, enc_rst : to encapsulator
//   enc_buf_r_en, enc_pct_txed                     : from encapsulator
module eth_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic               eth_tx_clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_r_en,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               abort,
    output logic               busy,
    output logic               eth_tx_en,
    output logic [1:0]         enc_buffer_ready,
    output logic [7:0]         enc_data,
    input  logic               enc_buf_r_en,
    input  logic               enc_pct_txed,
    output logic               enc_rst
);

    localparam int PW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(IFG_CYCLES + 1);

    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IFG_LOAD = IW'(IFG_CYCLES);
    localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);
    localparam logic [PW:0]   NQ       = (PW + 1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ABORT,
        IFG
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [N_REQ-1:0] done_d;
    logic [PW-1:0]    last_ptr;
    logic [PW-1:0]    ptr_d;
    logic [WW-1:0]    wd_cnt;
    logic [WW-1:0]    wd_d;
    logic [IW-1:0]    ifg_cnt;
    logic [IW-1:0]    ifg_d;

    logic             rr_found;
    logic [PW-1:0]    rr_idx;
    logic [PW:0]      rr_sum;

    // Scan starts one past the last winner, so the previous winner is
    // considered only after every other requester.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_sum = {1'b0, last_ptr} + (PW + 1)'(k);
            if (rr_sum >= NQ) begin
                rr_sum = rr_sum - NQ;
            end
            if (!rr_found && req[rr_sum[PW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        enc_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                enc_data = enc_data | req_data[8*i +: 8];
            end
        end
    end

    assign req_r_en = gnt & {N_REQ{enc_buf_r_en}};

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        ptr_d   = last_ptr;
        wd_d    = wd_cnt;
        ifg_d   = ifg_cnt;
        done_d  = '0;
        unique case (state)
            IDLE: begin
                gnt_d = '0;
                if (rr_found) begin
                    gnt_d   = N_REQ'(1) << rr_idx;
                    ptr_d   = rr_idx;
                    wd_d    = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Completion wins over a coincident timeout.
                if (enc_pct_txed) begin
                    done_d  = gnt;
                    ifg_d   = IFG_LOAD;
                    state_d = IFG;
                end else if (wd_cnt == WD_LAST) begin
                    state_d = ABORT;
                end else begin
                    wd_d = wd_cnt + WW'(1);
                end
            end
            ABORT: begin
                ifg_d   = IFG_LOAD;
                state_d = IFG;
            end
            IFG: begin
                // Grant held through the gap so the encapsulator can
                // drop pct_txed before anyone else is routed in.
                if (ifg_cnt == '0) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    ifg_d = ifg_cnt - IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Encapsulator controls are registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge eth_tx_clk) begin
        if (!rst) begin
            state            <= IDLE;
            gnt              <= '0;
            done             <= '0;
            last_ptr         <= PTR_RST;
            wd_cnt           <= '0;
            ifg_cnt          <= '0;
            abort            <= 1'b0;
            busy             <= 1'b0;
            eth_tx_en        <= 1'b0;
            enc_buffer_ready <= 2'b00;
            enc_rst          <= 1'b1;
        end else begin
            state            <= state_d;
            gnt              <= gnt_d;
            done             <= done_d;
            last_ptr         <= ptr_d;
            wd_cnt           <= wd_d;
            ifg_cnt          <= ifg_d;
            abort            <= (state_d == ABORT);
            busy             <= (state_d != IDLE);
            eth_tx_en        <= (state_d == SEND) || (state_d == IFG);
            enc_buffer_ready <= (state_d == SEND) ? 2'b01 : 2'b00;
            enc_rst          <= (state_d == ABORT);
        end
    end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler: table vectors, random frames
// against a transaction-level round-robin / timing model, reset corners.
module tb_eth_tx_scheduler;

    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int TO  = 64;

    logic         eth_tx_clk;
    logic         rst;
    logic [N-1:0] req;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_r_en;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         abort;
    logic         busy;
    logic         eth_tx_en;
    logic [1:0]   enc_buffer_ready;
    logic [7:0]   enc_data;
    logic         enc_buf_r_en;
    logic         enc_pct_txed;
    logic         enc_rst;

    int checks   = 0;
    int failures = 0;
    int mptr     = N - 1;

    eth_tx_scheduler #(
        .N_REQ(N),
        .IFG_CYCLES(IFG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .eth_tx_clk(eth_tx_clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_r_en(req_r_en),
        .gnt(gnt),
        .done(done),
        .abort(abort),
        .busy(busy),
        .eth_tx_en(eth_tx_en),
        .enc_buffer_ready(enc_buffer_ready),
        .enc_data(enc_data),
        .enc_buf_r_en(enc_buf_r_en),
        .enc_pct_txed(enc_pct_txed),
        .enc_rst(enc_rst)
    );

    initial eth_tx_clk = 1'b0;
    always #5 eth_tx_clk = ~eth_tx_clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge eth_tx_clk);
        @(negedge eth_tx_clk);
    endtask

    // Reference round-robin choice: first requester after the last winner.
    function automatic logic [N-1:0] pick(input int p, input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        for (int k = 1; k <= N; k++) begin
            if (g == '0 && r[(p + k) % N]) begin
                g[(p + k) % N] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic chk_reset(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_abort"}, 32'(abort), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_txen"}, 32'(eth_tx_en), 0);
        chk({nm, "_ebr"}, 32'(enc_buffer_ready), 0);
        chk({nm, "_encrst"}, 32'(enc_rst), 1);
    endtask

    // Called at a negedge with the DUT idle. len = SEND cycle in which
    // pct_txed is raised; len > TO means it never is.
    task automatic run_frame(input logic [N-1:0] r, input logic [N-1:0] eg,
                             input int len);
        logic [7:0] exp_d;
        int ncyc;
        int n;
        int bad;
        req = r;
        req_data = $urandom;
        enc_buf_r_en = 1'($urandom_range(0, 1));
        tick();
        chk("grant", 32'(gnt), 32'(eg));
        chk("busy_send", 32'(busy), 1);
        chk("txen_send", 32'(eth_tx_en), 1);
        chk("ebr_send", 32'(enc_buffer_ready), 1);
        exp_d = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) exp_d = req_data[8*i +: 8];
        end
        chk("enc_data", 32'(enc_data), 32'(exp_d));
        chk("req_r_en", 32'(req_r_en), enc_buf_r_en ? 32'(eg) : 0);
        mptr = idx_of(eg);
        ncyc = (len <= TO) ? len : TO;
        bad = 0;
        for (int c = 1; c <= ncyc; c++) begin
            enc_pct_txed = (c == len);
            tick();
            if (c < ncyc) begin
                if (done != '0 || abort || !busy || gnt != eg) bad++;
            end
        end
        enc_pct_txed = 1'b0;
        chk("send_stable", bad, 0);
        if (len <= TO) begin
            chk("done", 32'(done), 32'(eg));
            chk("no_abort", 32'(abort), 0);
            chk("ebr_ifg", 32'(enc_buffer_ready), 0);
            chk("txen_ifg", 32'(eth_tx_en), 1);
        end else begin
            chk("abort", 32'(abort), 1);
            chk("enc_rst_abort", 32'(enc_rst), 1);
            chk("no_done", 32'(done), 0);
            chk("txen_abort", 32'(eth_tx_en), 0);
        end
        n = 0;
        bad = 0;
        while (busy && n < 60) begin
            tick();
            n++;
            if (done != '0 || abort || enc_rst) bad++;
            if (busy && (gnt != eg || enc_buffer_ready != 2'b00)) bad++;
        end
        chk("gap_len", n, (len <= TO) ? IFG + 1 : IFG + 2);
        chk("gap_clean", bad, 0);
        chk("gnt_idle", 32'(gnt), 0);
    endtask

    typedef struct {
        logic [N-1:0] r;
        int           len;
        logic [N-1:0] eg;
    } vec_t;

    vec_t tbl[8];
    logic [N-1:0] fair[5];

    initial begin
        logic [N-1:0] rr;
        tbl[0] = '{4'b1111, 20,  4'b0001};
        tbl[1] = '{4'b1111, 64,  4'b0010};
        tbl[2] = '{4'b0101, 200, 4'b0100};
        tbl[3] = '{4'b0101, 1,   4'b0001};
        tbl[4] = '{4'b1000, 5,   4'b1000};
        tbl[5] = '{4'b0110, 40,  4'b0010};
        tbl[6] = '{4'b0010, 63,  4'b0010};
        tbl[7] = '{4'b1001, 10,  4'b1000};
        fair[0] = 4'b0001;
        fair[1] = 4'b0010;
        fair[2] = 4'b0100;
        fair[3] = 4'b1000;
        fair[4] = 4'b0001;

        rst = 1'b0;
        req = '0;
        req_data = '0;
        enc_buf_r_en = 1'b0;
        enc_pct_txed = 1'b0;
        repeat (3) @(posedge eth_tx_clk);
        @(negedge eth_tx_clk);
        chk_reset("por");
        chk("por_enc_data", 32'(enc_data), 0);
        rst = 1'b1;
        tick();
        chk("rel_enc_rst", 32'(enc_rst), 0);
        chk("rel_busy", 32'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].r, tbl[i].eg, tbl[i].len);
        end

        for (int i = 0; i < 20; i++) begin
            rr = 4'($urandom_range(1, 15));
            run_frame(rr, pick(mptr, rr), int'($urandom_range(1, 72)));
        end

        rr = 4'b1111;
        req = rr;
        req_data = 32'h11223344;
        tick();
        chk("mid_grant", 32'(gnt), 32'(pick(mptr, rr)));
        repeat (10) tick();
        rst = 1'b0;
        tick();
        chk_reset("mid_rst");
        req = '0;
        rst = 1'b1;
        tick();
        chk("mid_rel_enc_rst", 32'(enc_rst), 0);
        chk("mid_rel_busy", 32'(busy), 0);
        mptr = N - 1;

        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, fair[i], 30 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
